instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Write side of the instruction memory: loads a program into the word-addressed instruction memory before the datapath fetches it.
//  Takes a byte stream over a valid/ready handshake and packs bytes into 32-bit little-endian words.
//  Writes each word to consecutive addresses from 0 and holds the CPU (cpu_hold) until the load is complete.
// PARAMETERS
//  MEM_DEPTH  8                    number of 32-bit words in instruction memory
//  ADDR_W     $clog2(MEM_DEPTH)    word-address width (word index = PC value used for fetch)
// PORTS
//  clk         in   1          single clock; all state updates on posedge clk
//  rst_n       in   1          asynchronous, active-low reset
//  start       in   1          one-cycle pulse; begins a load (ignored while busy)
//  num_words   in   ADDR_W+1   words to load, sampled on accepted start
//  byte_valid  in   1          byte_data is valid
//  byte_data   in   8          program byte; first byte of a word goes to bits [7:0]
//  byte_ready  out  1          loader accepts a byte this cycle
//  mem_we      out  1          instruction-memory write enable (one cycle per word)
//  mem_addr    out  ADDR_W     word address of the write
//  mem_wdata   out  32         word written
//  busy        out  1          load in progress
//  done        out  1          load finished; held until next accepted start
//  cpu_hold    out  1          stall request to the datapath; equals busy
//  err         out  1          checksum mismatch (CHECKSUM_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: all outputs 0. State=IDLE. Counters and packer cleared. Reset mid-load discards any partial word; words already written stay in memory.
//  - FSM states: IDLE, RECV, WRITE, CHK (CHK exists only with CHECKSUM_EN), DONE.
//  - IDLE: byte_ready=0. On start:
//    - latch n = min(num_words, MEM_DEPTH); clear word count wc=0, byte index bi=0 and done.
//    - if n==0, go to DONE; else go to RECV.
//  - RECV: byte_ready=1. Each valid&&ready places byte_data in lane bi, then bi++.
//    - On the 4th byte, go to WRITE; bi wraps to 0.
//  - WRITE: one cycle with mem_we=1, mem_addr=wc, mem_wdata=packed word, byte_ready=0. Then wc++.
//    - If wc+1==n, go to DONE (or CHK with CHECKSUM_EN); else go to RECV.
//  - DONE: done=1, busy=0, byte_ready=0. Next accepted start restarts the load from address 0.
//  - busy=1 in RECV/WRITE/CHK. start is ignored while busy=1.
//  - Throughput: 5 cycles per word with back-to-back bytes. Gaps in byte_valid stretch RECV only.
//  - Bytes offered while byte_ready=0 are not consumed; the source holds them.
//  - mem_addr never exceeds n-1, so no wrap-around. num_words > MEM_DEPTH is clamped, and the excess bytes are never accepted.
// CONFIGURATION
//  CHECKSUM_EN defined:
//    - a running XOR of all written words is kept, cleared on start.
//    - after the last WRITE, CHK accepts 4 more bytes (same packing); this word is the expected checksum. No memory write.
//    - err=1 on mismatch, then go to DONE. err is sticky until the next accepted start.
//  CHECKSUM_EN undefined: no CHK state, no trailing bytes, err tied 0.
// STRUCTURE
//  - Package instr_loader_pkg:
//    - state_t enum (IDLE, RECV, WRITE, CHK, DONE)
//    - WORD_W=32, BYTES_PER_WORD=4, BYTE_W=8
//  - Sub-module byte_packer:
//    - inputs: clk, rst_n, clear, byte_valid&&byte_ready, byte_data
//    - outputs: word[31:0], word_full pulse on 4th byte
//    - reused by RECV and CHK
//  - Top level holds the FSM, wc, n and the checksum register.
// TESTING
//  1. Reset then start, num_words=2, bytes 13 00 00 00 93 00 10 00 back-to-back
//     -> writes addr0=0x00000013 and addr1=0x00100093; done=1 after 10 cycles + 1.
//  2. byte_valid toggling every other cycle during a 1-word load
//     -> exactly one mem_we; mem_wdata correct; byte_ready=0 in WRITE.
//  3. num_words=0 -> DONE next cycle, no mem_we. num_words=15 with MEM_DEPTH=8
//     -> exactly 8 writes, addr 0..7.
//  4. Assert rst_n low after 2 bytes of word 1
//     -> all outputs 0 immediately; a fresh load then writes from addr 0 with correct packing.
//  5. start pulsed while busy -> ignored; n and wc unchanged.
//  6. CHECKSUM_EN, words 0x11111111 and 0x22222222:
//     -> trailer 0x33333333 gives err=0
//     -> trailer 0x33333334 gives err=1 until next start

Source files
------------

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared states and word/byte geometry for the instruction-memory loader.
package instr_loader_pkg;
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs accepted bytes little-endian into a word; word_full pulses with the last byte.
module byte_packer
   import instr_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);
   localparam int BI_W = $clog2(BYTES_PER_WORD);
   logic [BI_W-1:0]   bi_q, bi_d;
   logic [WORD_W-1:0] word_q, word_d;
   always_comb begin
      bi_d   = bi_q;
      word_d = word_q;
      if (clear) begin
         bi_d   = '0;
         word_d = '0;
      end else if (accept) begin
         word_d[bi_q*BYTE_W +: BYTE_W] = byte_data;
         bi_d = bi_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bi_q   <= '0;
         word_q <= '0;
      end else begin
         bi_q   <= bi_d;
         word_q <= word_d;
      end
   assign word      = word_q;
   assign word_full = accept && (bi_q == BI_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams bytes into 32-bit words written to instruction memory from address 0, holding the CPU meanwhile.
// Optional trailing checksum word and err flag are enabled by defining CHECKSUM_EN.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int MEM_DEPTH = 8,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold,
   output logic              err
);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
`ifdef CHECKSUM_EN
   localparam state_t LAST = CHK;
`else
   localparam state_t LAST = DONE;
`endif
   state_t            state_q, state_d;
   logic [ADDR_W:0]   n_q, n_d, n_clamp;
   logic [ADDR_W-1:0] wc_q, wc_d;
   logic              clear, accept, word_full;
   logic [WORD_W-1:0] word;
`ifdef CHECKSUM_EN
   logic              err_q, err_d;
   logic [WORD_W-1:0] csum_q, csum_d;
`endif
   byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .accept    (accept),
      .byte_data (byte_data),
      .word      (word),
      .word_full (word_full)
   );
   assign n_clamp    = (num_words > DEPTH) ? DEPTH : num_words;
   assign byte_ready = (state_q == RECV) || (state_q == CHK);
   assign accept     = byte_valid && byte_ready;
   assign mem_we     = (state_q == WRITE);
   assign mem_addr   = wc_q;
   assign mem_wdata  = mem_we ? word : '0;
   assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHK);
   assign cpu_hold   = busy;
   assign done       = (state_q == DONE);
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wc_d    = wc_q;
      clear   = 1'b0;
`ifdef CHECKSUM_EN
      err_d   = err_q;
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE, DONE: if (start) begin
            n_d     = n_clamp;
            wc_d    = '0;
            clear   = 1'b1;
            state_d = (n_clamp == '0) ? DONE : RECV;
`ifdef CHECKSUM_EN
            err_d   = 1'b0;
            csum_d  = '0;
`endif
         end
         RECV: state_d = word_full ? WRITE : RECV;
         WRITE: begin
            wc_d    = wc_q + 1'b1;
            state_d = ({1'b0, wc_q} + 1'b1 == n_q) ? LAST : RECV;
`ifdef CHECKSUM_EN
            csum_d  = csum_q ^ word;
`endif
         end
`ifdef CHECKSUM_EN
         // The trailer's last byte is still on the bus, so compare the word as it completes.
         CHK: if (word_full) begin
            err_d   = {byte_data, word[WORD_W-BYTE_W-1:0]} != csum_q;
            state_d = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         wc_q    <= '0;
`ifdef CHECKSUM_EN
         err_q   <= 1'b0;
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wc_q    <= wc_d;
`ifdef CHECKSUM_EN
         err_q   <= err_d;
         csum_q  <= csum_d;
`endif
      end
`ifdef CHECKSUM_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule
